// File: rtl/i2c_master_pkg.sv
// ---------------------------------------------------------------------------
// i2c_master_pkg
//   Shared definitions for the I2C master byte controller and the bit
//   controller that sits beside it.
//   - bit-command encodings carried on bit_cmd between the two controllers
//   - byte FSM state encoding, also visible on the byte controller's
//     state_dbg output
// ---------------------------------------------------------------------------
package i2c_master_pkg;

  // Bit-controller commands.
  localparam logic [2:0] CMD_NOP   = 3'b000;
  localparam logic [2:0] CMD_START = 3'b001;
  localparam logic [2:0] CMD_STOP  = 3'b010;
  localparam logic [2:0] CMD_WRITE = 3'b100;
  localparam logic [2:0] CMD_READ  = 3'b011;

  // Byte-level sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_ACK   = 3'd4,
    ST_STOP  = 3'd5
  } byte_state_e;

  // A bit controller only finishes a command if one is actually pending.
  function automatic logic cmd_pending(input logic [2:0] cmd);
    return cmd != CMD_NOP;
  endfunction

endpackage

// File: rtl/i2c_master_byte_ctrl.sv
// ---------------------------------------------------------------------------
// i2c_master_byte_ctrl
//   Expands one byte-level command from the register block into a sequence
//   of single-bit commands for the I2C bit controller:
//     [START] -> 8 data bits -> ACK slot -> [STOP]
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   core_en           core enable; low holds the sequencer in IDLE
//   sta/sto/rd/wr     command bits from the register block
//   ack               ACK value to drive after a read (0 = ACK, 1 = NACK)
//   txr               byte to transmit
//   rxr               shift register contents (received byte)
//   done              one-cycle pulse when a command sequence completes
//   irxack            slave ACK bit sampled after a write
//   i2c_al            one-cycle pulse on arbitration loss
//   i2c_busy          registered copy of bit_busy
//   bit_cmd/bit_din   command and data bit presented to the bit controller
//   bit_ack           bit controller finished the current bit_cmd
//   bit_dout          bit sampled by a READ bit command
//   bit_al            arbitration lost, from the bit controller
//   bit_busy          bus busy, from the bit controller
//   state_dbg         current sequencer state (debug / checker hook)
//
// Handshake: bit_cmd/bit_din are a request held stable until the cycle in
// which bit_ack is high; on that edge the request is retired and the next
// one (or NOP) is loaded, so consecutive bits run back-to-back. bit_ack while
// bit_cmd is NOP carries no meaning and is ignored.
// ---------------------------------------------------------------------------
module i2c_master_byte_ctrl
  import i2c_master_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        core_en,
  input  logic        sta,
  input  logic        sto,
  input  logic        rd,
  input  logic        wr,
  input  logic        ack,
  input  logic [7:0]  txr,
  output logic [7:0]  rxr,
  output logic        done,
  output logic        irxack,
  output logic        i2c_al,
  output logic        i2c_busy,
  output logic [2:0]  bit_cmd,
  output logic        bit_din,
  input  logic        bit_ack,
  input  logic        bit_dout,
  input  logic        bit_al,
  input  logic        bit_busy,
  output byte_state_e state_dbg
);

  byte_state_e state_q, state_d;
  logic [2:0]  cmd_q, cmd_d;
  logic        din_q, din_d;
  logic [7:0]  sr_q, sr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        irxack_q, irxack_d;
  logic        al_q, al_d;
  logic        busy_q;
  // Remembers whether the byte in flight is a write, so the ACK slot knows
  // whether bit_dout is the slave's acknowledge.
  logic        was_wr_q, was_wr_d;

  // Retire strobe: the bit controller finished the pending request.
  logic        bit_done;
  // Set where the sequencer has to choose the data phase (IDLE after the
  // START priority check, or the end of a START bit).
  logic        pick_byte;

  assign bit_done = bit_ack && cmd_pending(cmd_q);

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    din_d     = din_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    irxack_d  = irxack_q;
    was_wr_d  = was_wr_q;
    done_d    = 1'b0;
    al_d      = 1'b0;
    pick_byte = 1'b0;

    if (bit_al) begin
      // Arbitration loss abandons the sequence silently (no done pulse);
      // a coincident bit_ack is discarded.
      al_d    = 1'b1;
      state_d = ST_IDLE;
      cmd_d   = CMD_NOP;
      cnt_d   = 3'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // The register block clears its command bits one edge after done,
          // so the commands seen while done is high are stale.
          if (!done_q) begin
            if (sta) begin
              state_d = ST_START;
              cmd_d   = CMD_START;
            end else begin
              pick_byte = 1'b1;
            end
          end
        end

        ST_START: begin
          if (bit_done) pick_byte = 1'b1;
        end

        ST_WRITE: begin
          if (bit_done) begin
            sr_d  = {sr_q[6:0], 1'b0};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              // ACK slot: read back the slave's acknowledge.
              state_d = ST_ACK;
              cmd_d   = CMD_READ;
            end else begin
              din_d = sr_q[6];
            end
          end
        end

        ST_READ: begin
          if (bit_done) begin
            sr_d  = {sr_q[6:0], bit_dout};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              // ACK slot: drive our own ACK/NACK.
              state_d = ST_ACK;
              cmd_d   = CMD_WRITE;
              din_d   = ack;
            end
          end
        end

        ST_ACK: begin
          if (bit_done) begin
            if (was_wr_q) irxack_d = bit_dout;
            if (sto) begin
              state_d = ST_STOP;
              cmd_d   = CMD_STOP;
            end else begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
              cmd_d   = CMD_NOP;
            end
          end
        end

        ST_STOP: begin
          if (bit_done) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
            cmd_d   = CMD_NOP;
          end
        end

        default: begin
          state_d = ST_IDLE;
          cmd_d   = CMD_NOP;
        end
      endcase

      if (pick_byte) begin
        if (rd) begin
          state_d  = ST_READ;
          cmd_d    = CMD_READ;
          was_wr_d = 1'b0;
        end else if (wr) begin
          state_d  = ST_WRITE;
          cmd_d    = CMD_WRITE;
          sr_d     = txr;
          din_d    = txr[7];
          was_wr_d = 1'b1;
        end else if (sto) begin
          state_d = ST_STOP;
          cmd_d   = CMD_STOP;
        end else if (state_q == ST_START) begin
          // START with nothing after it: the sequence ends here.
          done_d  = 1'b1;
          state_d = ST_IDLE;
          cmd_d   = CMD_NOP;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !core_en) begin
      state_q  <= ST_IDLE;
      cmd_q    <= CMD_NOP;
      din_q    <= 1'b0;
      sr_q     <= 8'h00;
      cnt_q    <= 3'd0;
      done_q   <= 1'b0;
      irxack_q <= 1'b0;
      al_q     <= 1'b0;
      busy_q   <= 1'b0;
      was_wr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      din_q    <= din_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      irxack_q <= irxack_d;
      al_q     <= al_d;
      busy_q   <= bit_busy;
      was_wr_q <= was_wr_d;
    end
  end

  assign rxr       = sr_q;
  assign done      = done_q;
  assign irxack    = irxack_q;
  assign i2c_al    = al_q;
  assign i2c_busy  = busy_q;
  assign bit_cmd   = cmd_q;
  assign bit_din   = din_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_i2c_master_byte_ctrl.sv
// ---------------------------------------------------------------------------
// tb_i2c_master_byte_ctrl
//   Drives byte commands into i2c_master_byte_ctrl and plays the part of the
//   bit controller. The expected bit-command stream ({cmd, din}) is queued
//   when a command is issued and popped as each bit command is acknowledged.
// ---------------------------------------------------------------------------
module tb_i2c_master_byte_ctrl;
  import i2c_master_pkg::*;

  localparam logic [2:0] C_NOP   = 3'b000;
  localparam logic [2:0] C_START = 3'b001;
  localparam logic [2:0] C_STOP  = 3'b010;
  localparam logic [2:0] C_WRITE = 3'b100;
  localparam logic [2:0] C_READ  = 3'b011;

  logic        clk = 1'b0;
  logic        rst, core_en, sta, sto, rd, wr, ack;
  logic [7:0]  txr, rxr;
  logic        done, irxack, i2c_al, i2c_busy;
  logic [2:0]  bit_cmd;
  logic        bit_din, bit_ack, bit_dout, bit_al, bit_busy;
  byte_state_e state_dbg;

  logic [3:0]  exp_q[$];
  logic        dout_q[$];
  int          num_checks = 0;
  int          num_errors = 0;
  logic        exp_irxack;

  i2c_master_byte_ctrl dut (
    .clk(clk), .rst(rst), .core_en(core_en),
    .sta(sta), .sto(sto), .rd(rd), .wr(wr), .ack(ack), .txr(txr),
    .rxr(rxr), .done(done), .irxack(irxack), .i2c_al(i2c_al),
    .i2c_busy(i2c_busy), .bit_cmd(bit_cmd), .bit_din(bit_din),
    .bit_ack(bit_ack), .bit_dout(bit_dout), .bit_al(bit_al),
    .bit_busy(bit_busy), .state_dbg(state_dbg)
  );

  // ---- clock / watchdog ----------------------------------------------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---- helpers -------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cmds();
    sta = 1'b0; sto = 1'b0; rd = 1'b0; wr = 1'b0;
  endtask

  task automatic push_bit(input logic [2:0] c, input logic d);
    exp_q.push_back({c, (c == C_WRITE) ? d : 1'b0});
  endtask

  // Queue the expected bit stream and bit controller read data, then issue
  // the command bits.
  task automatic plan_cmd(input logic s, input logic r, input logic w, input logic p,
                          input logic [7:0] tx, input logic [7:0] rx_data,
                          input logic ackv, input logic slave_ack);
    if (s) push_bit(C_START, 1'b0);
    if (r) begin
      for (int i = 7; i >= 0; i--) begin
        push_bit(C_READ, 1'b0);
        dout_q.push_back(rx_data[i]);
      end
      push_bit(C_WRITE, ackv);
    end else if (w) begin
      for (int i = 7; i >= 0; i--) push_bit(C_WRITE, tx[i]);
      push_bit(C_READ, 1'b0);
      dout_q.push_back(slave_ack);
    end
    if (p) push_bit(C_STOP, 1'b0);
    sta = s; rd = r; wr = w; sto = p; ack = ackv; txr = tx;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rxr"}, rxr, 8'h00);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_irxack"}, irxack, 1'b0);
    check({tag, "_al"}, i2c_al, 1'b0);
    check({tag, "_busy"}, i2c_busy, 1'b0);
    check({tag, "_bit_cmd"}, bit_cmd, C_NOP);
    check({tag, "_bit_din"}, bit_din, 1'b0);
    check({tag, "_state"}, state_dbg, ST_IDLE);
  endtask

  // Bit-controller model: acknowledges each pending bit command after `gap`
  // idle cycles. abort_kind at command number abort_at: 1 = arbitration
  // loss, 2 = rst, 3 = core_en low.
  task automatic run_seq(input int gap, input int abort_at, input int abort_kind);
    int         n, g, waited;
    bit         done_seen, al_seen, stable;
    logic [3:0] held, obs, e;
    n = 0; g = 0; waited = 0; done_seen = 0; al_seen = 0; stable = 1; held = '0;
    while (!done_seen && waited < 2000) begin
      if (i2c_al === 1'b1) al_seen = 1;
      if (done === 1'b1) begin
        done_seen = 1;
      end else begin
        bit_ack = 1'b0;
        bit_dout = 1'b0;
        if (bit_cmd != C_NOP) begin
          obs = {bit_cmd, (bit_cmd == C_WRITE) ? bit_din : 1'b0};
          if (g == 0) held = obs;
          else if (obs !== held) stable = 0;
          if (g >= gap) begin
            n++;
            if (gap > 0) check("stall_hold", stable, 1'b1);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hf;
            check("bit_cmd_seq", obs, e);
            g = 0;
            stable = 1;
            if (n == abort_at) begin
              if (abort_kind == 1) begin
                bit_al = 1'b1;
                bit_ack = 1'b1;
                step();
                bit_al = 1'b0;
                bit_ack = 1'b0;
                clear_cmds();
                check("al_pulse", i2c_al, 1'b1);
                check("al_bit_cmd", bit_cmd, C_NOP);
                check("al_no_done", done, 1'b0);
                check("al_state", state_dbg, ST_IDLE);
                step();
                check("al_width", i2c_al, 1'b0);
                check("al_no_done2", done, 1'b0);
                check("al_idle_hold", bit_cmd, C_NOP);
              end else begin
                if (abort_kind == 2) rst = 1'b1;
                else core_en = 1'b0;
                step();
                rst = 1'b0;
                core_en = 1'b1;
                clear_cmds();
                check_reset_outputs(abort_kind == 2 ? "rst_mid" : "dis_mid");
              end
              exp_q.delete();
              dout_q.delete();
              return;
            end
            bit_ack = 1'b1;
            if (bit_cmd == C_READ && dout_q.size() > 0) bit_dout = dout_q.pop_front();
          end else begin
            g++;
          end
        end
        step();
        waited++;
      end
    end
    bit_ack = 1'b0;
    bit_dout = 1'b0;
    check("seq_done", done_seen, 1'b1);
    check("exp_drained", exp_q.size(), 0);
    check("no_al", al_seen, 1'b0);
    // Command bits are still high across this edge; IDLE must ignore them.
    step();
    check("done_width", done, 1'b0);
    check("no_retrigger", bit_cmd, C_NOP);
    clear_cmds();
    step();
    check("idle_after", state_dbg, ST_IDLE);
    exp_q.delete();
    dout_q.delete();
  endtask

  // ---- stimulus ------------------------------------------------------------
  initial begin
    logic       s, r, w, p, ackv, sa;
    logic [7:0] tx, rxd;
    int         gap;

    rst = 1'b1; core_en = 1'b1; clear_cmds(); ack = 1'b0; txr = 8'h00;
    bit_ack = 1'b0; bit_dout = 1'b0; bit_al = 1'b0; bit_busy = 1'b1;
    step(); step(); step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();
    check("busy_follow1", i2c_busy, 1'b1);
    bit_busy = 1'b0;
    step();
    check("busy_follow0", i2c_busy, 1'b0);
    bit_busy = 1'b1;

    // Write A5 with START and STOP, slave ACKs.
    plan_cmd(1, 0, 1, 1, 8'hA5, 8'h00, 1'b0, 1'b0);
    run_seq(0, 0, 0);
    check("wr_a5_irxack", irxack, 1'b0);
    check("wr_a5_rxr", rxr, 8'h00);

    // Write with a 20-cycle stall on every bit, slave NACKs.
    plan_cmd(0, 0, 1, 0, 8'h3C, 8'h00, 1'b0, 1'b1);
    run_seq(20, 0, 0);
    check("wr_stall_irxack", irxack, 1'b1);

    // Read with NACK; irxack keeps the value of the last write.
    plan_cmd(0, 1, 0, 0, 8'h00, 8'h69, 1'b1, 1'b0);
    run_seq(0, 0, 0);
    check("rd_nack_rxr", rxr, 8'h69);
    check("rd_nack_irxack", irxack, 1'b1);

    // Reset during READ bit 5, then core_en low during READ bit 5.
    plan_cmd(0, 1, 0, 0, 8'h00, 8'hFF, 1'b0, 1'b0);
    run_seq(1, 6, 2);
    plan_cmd(0, 1, 0, 0, 8'h00, 8'hFF, 1'b0, 1'b0);
    run_seq(0, 6, 3);

    // Arbitration loss during the 4th WRITE bit (command 5 after START),
    // then the sequencer must accept a fresh read.
    plan_cmd(1, 0, 1, 1, 8'hC3, 8'h00, 1'b0, 1'b0);
    run_seq(0, 5, 1);
    plan_cmd(0, 1, 0, 1, 8'h00, 8'h5A, 1'b0, 1'b0);
    run_seq(0, 0, 0);
    check("post_al_rxr", rxr, 8'h5A);

    // STOP only, then START only.
    plan_cmd(0, 0, 0, 1, 8'h00, 8'h00, 1'b0, 1'b0);
    run_seq(0, 0, 0);
    check("stop_only_rxr", rxr, 8'h5A);
    plan_cmd(1, 0, 0, 0, 8'h00, 8'h00, 1'b0, 1'b0);
    run_seq(2, 0, 0);

    // Random byte commands.
    exp_irxack = irxack;
    for (int k = 0; k < 8; k++) begin
      s = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      w = ~r;
      p = 1'($urandom_range(0, 1));
      tx = 8'($urandom_range(0, 255));
      rxd = 8'($urandom_range(0, 255));
      ackv = 1'($urandom_range(0, 1));
      sa = 1'($urandom_range(0, 1));
      gap = $urandom_range(0, 3);
      plan_cmd(s, r, w, p, tx, rxd, ackv, sa);
      run_seq(gap, 0, 0);
      if (w) exp_irxack = sa;
      check("rand_rxr", rxr, r ? rxd : 8'h00);
      check("rand_irxack", irxack, exp_irxack);
    end

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
